// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
// Shared constants for the pending-write register scoreboard.
//   NUM_REGS  : entries per register class (GPR, SEG, MM)
//   CNT_W     : width of each pending-write counter
//   REG_ID_W  : width of a register ID
//   BANK_*    : bank index of each register class
//   *_id_e    : symbolic register IDs for GPR and segment registers
// No ports (package).
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int NUM_REGS  = 8;
    localparam int CNT_W     = 2;
    localparam int REG_ID_W  = 3;

    localparam int NUM_BANKS = 3;
    localparam int BANK_GPR  = 0;
    localparam int BANK_SEG  = 1;
    localparam int BANK_MM   = 2;

    typedef enum logic [REG_ID_W-1:0] {
        GPR_EAX = 3'd0,
        GPR_ECX = 3'd1,
        GPR_EDX = 3'd2,
        GPR_EBX = 3'd3,
        GPR_ESP = 3'd4,
        GPR_EBP = 3'd5,
        GPR_ESI = 3'd6,
        GPR_EDI = 3'd7
    } gpr_id_e;

    typedef enum logic [REG_ID_W-1:0] {
        SEG_ES = 3'd0,
        SEG_CS = 3'd1,
        SEG_SS = 3'd2,
        SEG_DS = 3'd3,
        SEG_FS = 3'd4,
        SEG_GS = 3'd5
    } seg_id_e;

    // True when an enabled port addresses entry idx.
    function automatic logic id_hit(input logic en,
                                    input logic [REG_ID_W-1:0] id,
                                    input logic [REG_ID_W-1:0] idx);
        return en && (id == idx);
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_bank.sv
// -----------------------------------------------------------------------------
// sb_bank
// One bank of pending-write counters (one counter per register in a class).
// Ports:
//   clk_i            : clock
//   rst_n_i          : synchronous active-low reset, clears every counter
//   flush_i          : discard all pending writes (counters -> 0 next cycle)
//   inc0_*/inc1_*    : two increment ports (id, enable) from issue
//   dec0_*/dec1_*    : two decrement ports (id, enable) from retire
//   nz_o             : per-entry "counter non-zero" vector
//   err_o            : single-cycle pulse on counter overflow or underflow
// -----------------------------------------------------------------------------
module sb_bank
    import reg_scoreboard_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                flush_i,
    input  logic [REG_ID_W-1:0] inc0_id_i,
    input  logic                inc0_en_i,
    input  logic [REG_ID_W-1:0] inc1_id_i,
    input  logic                inc1_en_i,
    input  logic [REG_ID_W-1:0] dec0_id_i,
    input  logic                dec0_en_i,
    input  logic [REG_ID_W-1:0] dec1_id_i,
    input  logic                dec1_en_i,
    output logic [NUM_REGS-1:0] nz_o,
    output logic                err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_REGS-1:0] err_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             inc;
            logic             dec;
            logic             err;

            always_comb begin
                // OR of the two ports: both ports naming the same entry
                // still counts as a single +1 / -1.
                inc   = id_hit(inc0_en_i, inc0_id_i, REG_ID_W'(gi)) ||
                        id_hit(inc1_en_i, inc1_id_i, REG_ID_W'(gi));
                dec   = id_hit(dec0_en_i, dec0_id_i, REG_ID_W'(gi)) ||
                        id_hit(dec1_en_i, dec1_id_i, REG_ID_W'(gi));
                cnt_d = cnt_q;
                err   = 1'b0;
                if (flush_i) begin
                    cnt_d = '0;
                end else if (inc && !dec) begin
                    if (cnt_q == CNT_MAX) begin
                        err = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (dec && !inc) begin
                    if (cnt_q == '0) begin
                        err = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                // inc && dec on the same entry: net zero, counter unchanged.
            end

            always_ff @(posedge clk_i) begin
                if (!rst_n_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign nz_o[gi]    = |cnt_q;
            assign err_vec[gi] = err;
        end
    endgenerate

    assign err_o = |err_vec;

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
// Pending-write scoreboard between the decoder and the decode/AG latch.
// Counts in-flight writes per GPR, segment and MM register, raises
// DEP_STALL when a needed source has a pending write, and produces ISSUE.
// Ports:
//   CLK, RST_N            : clock, synchronous active-low reset
//   FLUSH                 : discard all in-flight writes
//   PIPE_STALL            : downstream stall, blocks ISSUE
//   D_V                   : decode valid
//   SR*/SIB_I/SEG* _ID    : source register IDs; *_NEEDED source-used flags
//   MM1/MM2_NEEDED        : MM sources, addressed by SR1_ID / SR2_ID
//   D_DRID1/2, D_LD_*     : decode destinations and write enables
//   WB_V, WB_DRID1/2, WB_LD_* : retiring destinations and write enables
//   DEP_STALL             : register dependency stall (combinational)
//   ISSUE                 : instruction leaves decode this cycle
//   SB_ERR                : sticky counter overflow/underflow flag
//   STALL_CNT             : saturating count of DEP_STALL cycles
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                FLUSH,
    input  logic                PIPE_STALL,
    input  logic                D_V,
    input  logic [REG_ID_W-1:0] SR1_ID,
    input  logic [REG_ID_W-1:0] SR2_ID,
    input  logic [REG_ID_W-1:0] SR3_ID,
    input  logic [REG_ID_W-1:0] SIB_I_ID,
    input  logic [REG_ID_W-1:0] SEG1_ID,
    input  logic [REG_ID_W-1:0] SEG2_ID,
    input  logic                SR1_NEEDED,
    input  logic                SR2_NEEDED,
    input  logic                SR3_NEEDED,
    input  logic                SIB_I_NEEDED,
    input  logic                SEG1_NEEDED,
    input  logic                SEG2_NEEDED,
    input  logic                MM1_NEEDED,
    input  logic                MM2_NEEDED,
    input  logic [REG_ID_W-1:0] D_DRID1,
    input  logic [REG_ID_W-1:0] D_DRID2,
    input  logic                D_LD_GPR1,
    input  logic                D_LD_GPR2,
    input  logic                D_LD_SEG,
    input  logic                D_LD_CSEG,
    input  logic                D_LD_MM,
    input  logic                WB_V,
    input  logic [REG_ID_W-1:0] WB_DRID1,
    input  logic [REG_ID_W-1:0] WB_DRID2,
    input  logic                WB_LD_GPR1,
    input  logic                WB_LD_GPR2,
    input  logic                WB_LD_SEG,
    input  logic                WB_LD_CSEG,
    input  logic                WB_LD_MM,
    output logic                DEP_STALL,
    output logic                ISSUE,
    output logic                SB_ERR,
    output logic [15:0]         STALL_CNT
);

    // Per-bank port bundles: [bank][port]
    logic [NUM_BANKS-1:0][1:0][REG_ID_W-1:0] inc_id;
    logic [NUM_BANKS-1:0][1:0]               inc_en;
    logic [NUM_BANKS-1:0][1:0][REG_ID_W-1:0] dec_id;
    logic [NUM_BANKS-1:0][1:0]               dec_en;
    logic [NUM_BANKS-1:0][NUM_REGS-1:0]      bank_nz;
    logic [NUM_BANKS-1:0]                    bank_err;

    logic        dep_stall;
    logic        issue;
    logic        sb_err_q,    sb_err_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Source lookup against the registered counters only; a retire this
    // cycle releases the stall next cycle.
    always_comb begin
        dep_stall = D_V & (
            (SR1_NEEDED   & bank_nz[BANK_GPR][SR1_ID])   |
            (SR2_NEEDED   & bank_nz[BANK_GPR][SR2_ID])   |
            (SR3_NEEDED   & bank_nz[BANK_GPR][SR3_ID])   |
            (SIB_I_NEEDED & bank_nz[BANK_GPR][SIB_I_ID]) |
            (SEG1_NEEDED  & bank_nz[BANK_SEG][SEG1_ID])  |
            (SEG2_NEEDED  & bank_nz[BANK_SEG][SEG2_ID])  |
            (MM1_NEEDED   & bank_nz[BANK_MM][SR1_ID])    |
            (MM2_NEEDED   & bank_nz[BANK_MM][SR2_ID]));
        issue = D_V & ~dep_stall & ~PIPE_STALL;
    end

    // Destination routing: GPR uses both DRIDs, SEG and MM use DRID1 only.
    always_comb begin
        inc_id = '0;
        inc_en = '0;
        dec_id = '0;
        dec_en = '0;

        inc_id[BANK_GPR][0] = D_DRID1;
        inc_en[BANK_GPR][0] = issue & D_LD_GPR1;
        inc_id[BANK_GPR][1] = D_DRID2;
        inc_en[BANK_GPR][1] = issue & D_LD_GPR2;
        inc_id[BANK_SEG][0] = D_DRID1;
        inc_en[BANK_SEG][0] = issue & (D_LD_SEG | D_LD_CSEG);
        inc_id[BANK_MM][0]  = D_DRID1;
        inc_en[BANK_MM][0]  = issue & D_LD_MM;

        dec_id[BANK_GPR][0] = WB_DRID1;
        dec_en[BANK_GPR][0] = WB_V & WB_LD_GPR1;
        dec_id[BANK_GPR][1] = WB_DRID2;
        dec_en[BANK_GPR][1] = WB_V & WB_LD_GPR2;
        dec_id[BANK_SEG][0] = WB_DRID1;
        dec_en[BANK_SEG][0] = WB_V & (WB_LD_SEG | WB_LD_CSEG);
        dec_id[BANK_MM][0]  = WB_DRID1;
        dec_en[BANK_MM][0]  = WB_V & WB_LD_MM;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            sb_bank u_bank (
                .clk_i     (CLK),
                .rst_n_i   (RST_N),
                .flush_i   (FLUSH),
                .inc0_id_i (inc_id[gi][0]),
                .inc0_en_i (inc_en[gi][0]),
                .inc1_id_i (inc_id[gi][1]),
                .inc1_en_i (inc_en[gi][1]),
                .dec0_id_i (dec_id[gi][0]),
                .dec0_en_i (dec_en[gi][0]),
                .dec1_id_i (dec_id[gi][1]),
                .dec1_en_i (dec_en[gi][1]),
                .nz_o      (bank_nz[gi]),
                .err_o     (bank_err[gi])
            );
        end
    endgenerate

    always_comb begin
        sb_err_d    = sb_err_q | (|bank_err);
        stall_cnt_d = stall_cnt_q;
        if (dep_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // STALL_CNT deliberately ignores FLUSH; only reset clears it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sb_err_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            sb_err_q    <= sb_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign DEP_STALL = dep_stall;
    assign ISSUE     = issue;
    assign SB_ERR    = sb_err_q;
    assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
// Directed self-checking bench for reg_scoreboard. Inputs change 1 time unit
// after the rising edge; outputs are checked before the next rising edge.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    logic        CLK = 1'b0;
    logic        RST_N, FLUSH, PIPE_STALL, D_V;
    logic [2:0]  SR1_ID, SR2_ID, SR3_ID, SIB_I_ID, SEG1_ID, SEG2_ID;
    logic        SR1_NEEDED, SR2_NEEDED, SR3_NEEDED, SIB_I_NEEDED;
    logic        SEG1_NEEDED, SEG2_NEEDED, MM1_NEEDED, MM2_NEEDED;
    logic [2:0]  D_DRID1, D_DRID2;
    logic        D_LD_GPR1, D_LD_GPR2, D_LD_SEG, D_LD_CSEG, D_LD_MM;
    logic        WB_V;
    logic [2:0]  WB_DRID1, WB_DRID2;
    logic        WB_LD_GPR1, WB_LD_GPR2, WB_LD_SEG, WB_LD_CSEG, WB_LD_MM;
    logic        DEP_STALL, ISSUE, SB_ERR;
    logic [15:0] STALL_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    reg_scoreboard dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .PIPE_STALL(PIPE_STALL), .D_V(D_V),
        .SR1_ID(SR1_ID), .SR2_ID(SR2_ID), .SR3_ID(SR3_ID), .SIB_I_ID(SIB_I_ID),
        .SEG1_ID(SEG1_ID), .SEG2_ID(SEG2_ID),
        .SR1_NEEDED(SR1_NEEDED), .SR2_NEEDED(SR2_NEEDED), .SR3_NEEDED(SR3_NEEDED),
        .SIB_I_NEEDED(SIB_I_NEEDED), .SEG1_NEEDED(SEG1_NEEDED), .SEG2_NEEDED(SEG2_NEEDED),
        .MM1_NEEDED(MM1_NEEDED), .MM2_NEEDED(MM2_NEEDED),
        .D_DRID1(D_DRID1), .D_DRID2(D_DRID2),
        .D_LD_GPR1(D_LD_GPR1), .D_LD_GPR2(D_LD_GPR2), .D_LD_SEG(D_LD_SEG),
        .D_LD_CSEG(D_LD_CSEG), .D_LD_MM(D_LD_MM),
        .WB_V(WB_V), .WB_DRID1(WB_DRID1), .WB_DRID2(WB_DRID2),
        .WB_LD_GPR1(WB_LD_GPR1), .WB_LD_GPR2(WB_LD_GPR2), .WB_LD_SEG(WB_LD_SEG),
        .WB_LD_CSEG(WB_LD_CSEG), .WB_LD_MM(WB_LD_MM),
        .DEP_STALL(DEP_STALL), .ISSUE(ISSUE), .SB_ERR(SB_ERR), .STALL_CNT(STALL_CNT)
    );

    task automatic clear_inputs();
        FLUSH = 0; PIPE_STALL = 0; D_V = 0;
        SR1_ID = 0; SR2_ID = 0; SR3_ID = 0; SIB_I_ID = 0; SEG1_ID = 0; SEG2_ID = 0;
        SR1_NEEDED = 0; SR2_NEEDED = 0; SR3_NEEDED = 0; SIB_I_NEEDED = 0;
        SEG1_NEEDED = 0; SEG2_NEEDED = 0; MM1_NEEDED = 0; MM2_NEEDED = 0;
        D_DRID1 = 0; D_DRID2 = 0;
        D_LD_GPR1 = 0; D_LD_GPR2 = 0; D_LD_SEG = 0; D_LD_CSEG = 0; D_LD_MM = 0;
        WB_V = 0; WB_DRID1 = 0; WB_DRID2 = 0;
        WB_LD_GPR1 = 0; WB_LD_GPR2 = 0; WB_LD_SEG = 0; WB_LD_CSEG = 0; WB_LD_MM = 0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
        $display("check %-22s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Issue one instruction that writes GPR id via DRID1.
    task automatic issue_gpr(input logic [2:0] id);
        clear_inputs();
        D_V = 1; D_DRID1 = id; D_LD_GPR1 = 1;
        tick();
        clear_inputs();
    endtask

    task automatic retire_gpr(input logic [2:0] id);
        clear_inputs();
        WB_V = 1; WB_DRID1 = id; WB_LD_GPR1 = 1;
        tick();
        clear_inputs();
    endtask

    task automatic need_sr1(input logic [2:0] id);
        clear_inputs();
        D_V = 1; SR1_ID = id; SR1_NEEDED = 1;
        settle();
    endtask

    initial begin
        clear_inputs();
        RST_N = 0;
        tick(); tick();
        RST_N = 1;

        // Reset state and basic issue
        need_sr1(3'd3);
        check("reset_dep_stall", 16'(DEP_STALL), 16'd0);
        check("reset_issue", 16'(ISSUE), 16'd1);
        check("reset_sb_err", 16'(SB_ERR), 16'd0);
        check("reset_stall_cnt", STALL_CNT, 16'd0);
        PIPE_STALL = 1; settle();
        check("pipe_stall_blocks", 16'(ISSUE), 16'd0);

        // GPR 2 dependency through SR2, released one cycle after retire
        issue_gpr(3'd2);
        D_V = 1; SR2_ID = 3'd2; SR2_NEEDED = 1; settle();
        check("gpr2_stall", 16'(DEP_STALL), 16'd1);
        check("gpr2_no_issue", 16'(ISSUE), 16'd0);
        tick();                                   // stall cycle 1
        WB_V = 1; WB_DRID1 = 3'd2; WB_LD_GPR1 = 1; settle();
        check("gpr2_no_bypass", 16'(DEP_STALL), 16'd1);
        tick();                                   // stall cycle 2, retire
        WB_V = 0; WB_LD_GPR1 = 0; settle();
        check("gpr2_released", 16'(DEP_STALL), 16'd0);
        check("gpr2_issue_again", 16'(ISSUE), 16'd1);
        check("stall_cnt_two", STALL_CNT, 16'd2);
        clear_inputs();

        // Segment write via LD_CSEG to SEG 1
        D_V = 1; D_DRID1 = 3'd1; D_LD_CSEG = 1;
        tick();
        clear_inputs();
        D_V = 1; SEG2_ID = 3'd1; SEG2_NEEDED = 1; settle();
        check("seg1_stall", 16'(DEP_STALL), 16'd1);
        need_sr1(3'd1);
        check("gpr1_not_pending", 16'(DEP_STALL), 16'd0);
        clear_inputs();
        WB_V = 1; WB_DRID1 = 3'd1; WB_LD_SEG = 1;
        tick();
        clear_inputs();
        D_V = 1; SEG2_ID = 3'd1; SEG2_NEEDED = 1; settle();
        check("seg1_released", 16'(DEP_STALL), 16'd0);

        // MM 1 write; MM1 uses SR1_ID, MM2 uses SR2_ID
        clear_inputs();
        D_V = 1; D_DRID1 = 3'd1; D_LD_MM = 1;
        tick();
        clear_inputs();
        D_V = 1; SR1_ID = 3'd1; MM1_NEEDED = 1; settle();
        check("mm1_stall", 16'(DEP_STALL), 16'd1);
        clear_inputs();
        D_V = 1; SR2_ID = 3'd1; MM2_NEEDED = 1; settle();
        check("mm2_stall", 16'(DEP_STALL), 16'd1);
        clear_inputs();
        WB_V = 1; WB_DRID1 = 3'd1; WB_LD_MM = 1;
        tick();
        clear_inputs();
        D_V = 1; SR1_ID = 3'd1; MM1_NEEDED = 1; settle();
        check("mm1_released", 16'(DEP_STALL), 16'd0);
        clear_inputs();

        // GPR 5: same-cycle issue and retire leaves the count at 1
        issue_gpr(3'd5);
        D_V = 1; D_DRID1 = 3'd5; D_LD_GPR1 = 1;
        WB_V = 1; WB_DRID1 = 3'd5; WB_LD_GPR1 = 1;
        tick();
        clear_inputs();
        D_V = 1; SR3_ID = 3'd5; SR3_NEEDED = 1; settle();
        check("gpr5_net_zero_stall", 16'(DEP_STALL), 16'd1);
        retire_gpr(3'd5);
        D_V = 1; SR3_ID = 3'd5; SR3_NEEDED = 1; settle();
        check("gpr5_released", 16'(DEP_STALL), 16'd0);
        clear_inputs();

        // GPR 4 written through both DRIDs counts once, retired through both once
        D_V = 1; D_DRID1 = 3'd4; D_DRID2 = 3'd4; D_LD_GPR1 = 1; D_LD_GPR2 = 1;
        tick();
        clear_inputs();
        D_V = 1; SIB_I_ID = 3'd4; SIB_I_NEEDED = 1; settle();
        check("gpr4_dup_stall", 16'(DEP_STALL), 16'd1);
        clear_inputs();
        WB_V = 1; WB_DRID1 = 3'd4; WB_DRID2 = 3'd4; WB_LD_GPR1 = 1; WB_LD_GPR2 = 1;
        tick();
        clear_inputs();
        D_V = 1; SIB_I_ID = 3'd4; SIB_I_NEEDED = 1; settle();
        check("gpr4_dup_released", 16'(DEP_STALL), 16'd0);
        check("gpr4_no_err", 16'(SB_ERR), 16'd0);
        clear_inputs();

        // Overflow on GPR 0: counter saturates at 3
        issue_gpr(3'd0);
        issue_gpr(3'd0);
        issue_gpr(3'd0);
        settle();
        check("ovf_before", 16'(SB_ERR), 16'd0);
        issue_gpr(3'd0);
        check("ovf_err", 16'(SB_ERR), 16'd1);
        retire_gpr(3'd0);
        retire_gpr(3'd0);
        need_sr1(3'd0);
        check("ovf_held_at_3", 16'(DEP_STALL), 16'd1);
        clear_inputs();
        retire_gpr(3'd0);
        need_sr1(3'd0);
        check("ovf_drained", 16'(DEP_STALL), 16'd0);
        check("err_sticky", 16'(SB_ERR), 16'd1);
        clear_inputs();

        // Reset clears error and stall count; then underflow on GPR 7
        RST_N = 0;
        tick();
        RST_N = 1; settle();
        check("rst2_sb_err", 16'(SB_ERR), 16'd0);
        check("rst2_stall_cnt", STALL_CNT, 16'd0);
        retire_gpr(3'd7);
        check("udf_err", 16'(SB_ERR), 16'd1);
        need_sr1(3'd7);
        check("udf_held_at_0", 16'(DEP_STALL), 16'd0);
        clear_inputs();

        // Flush discards pending GPR 6; STALL_CNT survives flush
        issue_gpr(3'd6);
        need_sr1(3'd6);
        check("gpr6_stall", 16'(DEP_STALL), 16'd1);
        FLUSH = 1;
        tick();                                   // stall cycle 1 after reset
        FLUSH = 0; settle();
        check("flush_released", 16'(DEP_STALL), 16'd0);
        check("flush_keeps_cnt", STALL_CNT, 16'd1);
        clear_inputs();

        // Saturate STALL_CNT with a held dependency
        issue_gpr(3'd6);
        need_sr1(3'd6);
        repeat (65533) tick();
        check("stall_cnt_fffe", STALL_CNT, 16'hFFFE);
        tick();
        check("stall_cnt_ffff", STALL_CNT, 16'hFFFF);
        repeat (3) tick();
        check("stall_cnt_sat", STALL_CNT, 16'hFFFF);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
